// File: rtl/beat_tempo_tracker.sv
// Beat tempo tracker: measures inter-beat intervals in frames, averages the last
// HIST of them and converts the interval sum to BPM with a serial restoring divider.
module beat_tempo_tracker #(
    parameter int unsigned FLUX_W         = 70,
    parameter int unsigned INT_W          = 8,
    parameter int unsigned HIST           = 8,
    parameter int unsigned MIN_INTERVAL   = 4,
    parameter int unsigned MAX_INTERVAL   = 200,
    parameter int unsigned FRAMES_PER_MIN = 2812,
    parameter int unsigned QW             = 16,
    parameter int unsigned BPM_W          = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flux_valid,
    input  logic              beat_valid,
    input  logic [FLUX_W-1:0] flux_value,
    output logic [BPM_W-1:0]  bpm,
    output logic              bpm_valid,
    output logic              locked,
    output logic              beat_pulse,
    output logic [FLUX_W-1:0] beat_strength,
    output logic [INT_W-1:0]  interval_last,
    output logic              timeout
);

    localparam int unsigned HIST_W  = $clog2(HIST);
    localparam int unsigned PTR_W   = (HIST_W > 0) ? HIST_W : 1;
    localparam int unsigned SUM_W   = INT_W + HIST_W;
    localparam int unsigned FILL_W  = HIST_W + 1;
    localparam int unsigned CNT_W   = ($clog2(QW) > 0) ? $clog2(QW) : 1;
    localparam int unsigned NUM     = FRAMES_PER_MIN * HIST;
    localparam int unsigned BPM_MAX = (1 << BPM_W) - 1;

    typedef enum logic {
        IDLE,
        TRACK
    } trk_state_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    trk_state_t         state;
    div_state_t         div_state;
    logic               flux_valid_d;
    logic [INT_W-1:0]   frame_cnt;
    logic [INT_W-1:0]   hist [HIST];
    logic [PTR_W-1:0]   wr_ptr;
    logic [FILL_W-1:0]  fill;
    logic [SUM_W-1:0]   sum;

    logic [SUM_W-1:0]   den;
    logic [SUM_W-1:0]   rem;
    logic [QW-1:0]      quo;
    logic [CNT_W-1:0]   div_cnt;
    logic               div_pend;

    logic               frame_tick_c;
    logic [INT_W-1:0]   iv_c;
    logic               start_c;
    logic               accept_c;
    logic               drop_c;
    logic [SUM_W-1:0]   sum_new_c;
    logic [FILL_W-1:0]  fill_new_c;
    logic [PTR_W-1:0]   ptr_new_c;
    logic               div_req_c;
    logic [SUM_W:0]     trial_c;
    logic               ge_c;
    logic [SUM_W-1:0]   rem_next_c;

    // Frame qualification and the interval/history update values
    always_comb begin
        frame_tick_c = flux_valid & ~flux_valid_d;
        iv_c         = frame_cnt + INT_W'(1);
        start_c      = frame_tick_c & beat_valid & (state == IDLE);
        accept_c     = frame_tick_c & beat_valid & (state == TRACK)
                     & (iv_c >= INT_W'(MIN_INTERVAL));
        drop_c       = frame_tick_c & ~beat_valid & (state == TRACK)
                     & (iv_c == INT_W'(MAX_INTERVAL));
        sum_new_c    = sum - SUM_W'(hist[wr_ptr]) + SUM_W'(iv_c);
        fill_new_c   = (fill == FILL_W'(HIST)) ? fill : fill + FILL_W'(1);
        ptr_new_c    = (wr_ptr == PTR_W'(HIST - 1)) ? '0 : wr_ptr + PTR_W'(1);
        div_req_c    = accept_c & (fill_new_c == FILL_W'(HIST));
    end

    // One restoring step: shift the next dividend bit in, subtract if it fits
    always_comb begin
        trial_c    = {rem, quo[QW-1]};
        ge_c       = (trial_c >= {1'b0, den});
        rem_next_c = ge_c ? SUM_W'(trial_c - {1'b0, den}) : SUM_W'(trial_c);
    end

    // Beat tracker: refractory, interval history, timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            flux_valid_d  <= 1'b0;
            frame_cnt     <= '0;
            for (int i = 0; i < HIST; i++) hist[i] <= '0;
            wr_ptr        <= '0;
            fill          <= '0;
            sum           <= '0;
            locked        <= 1'b0;
            beat_pulse    <= 1'b0;
            beat_strength <= '0;
            interval_last <= '0;
            timeout       <= 1'b0;
        end else begin
            flux_valid_d <= flux_valid;
            beat_pulse   <= 1'b0;
            timeout      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_c) begin
                        state         <= TRACK;
                        frame_cnt     <= '0;
                        beat_pulse    <= 1'b1;
                        beat_strength <= flux_value;
                    end
                end
                TRACK: begin
                    if (accept_c) begin
                        hist[wr_ptr]  <= iv_c;
                        sum           <= sum_new_c;
                        wr_ptr        <= ptr_new_c;
                        fill          <= fill_new_c;
                        locked        <= (fill_new_c == FILL_W'(HIST));
                        interval_last <= iv_c;
                        frame_cnt     <= '0;
                        beat_pulse    <= 1'b1;
                        beat_strength <= flux_value;
                    end else if (drop_c) begin
                        for (int i = 0; i < HIST; i++) hist[i] <= '0;
                        sum       <= '0;
                        fill      <= '0;
                        wr_ptr    <= '0;
                        frame_cnt <= '0;
                        locked    <= 1'b0;
                        timeout   <= 1'b1;
                        state     <= IDLE;
                    end else if (frame_tick_c) begin
                        frame_cnt <= iv_c;
                    end
                end
            endcase
        end
    end

    // Serial divider: bpm = (FRAMES_PER_MIN*HIST) / sum, one quotient bit per cycle.
    // A pending request is dropped on timeout since the history it refers to is gone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_state <= DIV_IDLE;
            den       <= '0;
            rem       <= '0;
            quo       <= '0;
            div_cnt   <= '0;
            div_pend  <= 1'b0;
            bpm       <= '0;
            bpm_valid <= 1'b0;
        end else begin
            bpm_valid <= 1'b0;
            case (div_state)
                DIV_IDLE: begin
                    if (div_req_c) begin
                        den       <= sum_new_c;
                        rem       <= '0;
                        quo       <= QW'(NUM);
                        div_cnt   <= '0;
                        div_state <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    if (div_req_c) div_pend <= 1'b1;
                    rem     <= rem_next_c;
                    quo     <= {quo[QW-2:0], ge_c};
                    div_cnt <= div_cnt + CNT_W'(1);
                    if (div_cnt == CNT_W'(QW - 1)) div_state <= DIV_DONE;
                end
                DIV_DONE: begin
                    bpm       <= (quo > QW'(BPM_MAX)) ? BPM_W'(BPM_MAX) : BPM_W'(quo);
                    bpm_valid <= 1'b1;
                    div_pend  <= 1'b0;
                    if (div_req_c || (div_pend && !drop_c)) begin
                        den       <= div_req_c ? sum_new_c : sum;
                        rem       <= '0;
                        quo       <= QW'(NUM);
                        div_cnt   <= '0;
                        div_state <= DIV_RUN;
                    end else begin
                        div_state <= DIV_IDLE;
                    end
                end
                default: div_state <= DIV_IDLE;
            endcase
            if (drop_c) div_pend <= 1'b0;
        end
    end

endmodule
